// File: rtl/crossing_pkg.sv
// crossing_pkg: shared types and constants for the level-crossing arbiter.
//   state_e     - controller states
//   cancela_e   - barrier motor command codes
//   semaforo_e  - warning light codes
//   GRANT_E/W   - bit positions of the east/west owner in the grant vector
package crossing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARN,
    ST_LOWER,
    ST_CLOSED,
    ST_RAISE,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    CAN_STOP  = 2'b00,
    CAN_LOWER = 2'b01,
    CAN_RAISE = 2'b10
  } cancela_e;

  typedef enum logic [1:0] {
    SEM_OFF = 2'b00,
    SEM_RED = 2'b01
  } semaforo_e;

  localparam int GRANT_E = 0;
  localparam int GRANT_W = 1;

  // Round-robin pick: a lone request wins; on a tie the direction opposite
  // the last grant wins.
  function automatic logic pick_east(input logic req_e, input logic req_w,
                                     input logic last_west);
    return req_e && (!req_w || last_west);
  endfunction

  function automatic logic [1:0] grant_onehot(input logic east);
    return east ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/crossing_if.sv
// crossing_if: train sensors, barrier limit switches and controller outputs.
//   req_e/req_w       train approaching (entry sensors)
//   clear_e/clear_w   train has passed the exit sensor
//   gate_down/gate_up barrier limit switches
//   cancela           motor command (00 stop, 01 lower, 10 raise)
//   semaforo          light (00 off, 01 red)
//   grant             one-hot owner ([0] east, [1] west)
//   fault             sticky motor-timeout indication
// modport master: environment side; modport slave: controller side.
interface crossing_if;
  logic       req_e;
  logic       req_w;
  logic       clear_e;
  logic       clear_w;
  logic       gate_down;
  logic       gate_up;
  logic [1:0] cancela;
  logic [1:0] semaforo;
  logic [1:0] grant;
  logic       fault;

  modport master (
    output req_e, req_w, clear_e, clear_w, gate_down, gate_up,
    input  cancela, semaforo, grant, fault
  );

  modport slave (
    input  req_e, req_w, clear_e, clear_w, gate_down, gate_up,
    output cancela, semaforo, grant, fault
  );
endinterface

// File: rtl/crossing_timer.sv
// crossing_timer: loadable down-counter used for warning and motor timeouts.
//   clk, reset  clock, synchronous active-low reset
//   load        reload the counter with value (wins over en)
//   value       reload value
//   en          decrement while non-zero
//   expired     count is zero
module crossing_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values; = here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (en && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/crossing_arbiter.sv
// crossing_arbiter: two-track level-crossing controller. Grants the crossing
// to one direction, warns, lowers the barrier, hands over to a pending
// opposite train while closed, raises, and latches a fault on motor timeout.
//   clk    single clock, rising edge
//   reset  synchronous active-low reset
//   bus    crossing_if.slave (sensors in, motor/light/grant/fault out)
// Optional feature: define CROSSING_BLINK_EN to blink the light in WARN and
// FAULT with half-period BLINK_CYCLES; otherwise the light is steady red.
module crossing_arbiter
  import crossing_pkg::*;
#(
  parameter int WARN_CYCLES  = 4,
  parameter int MOVE_TIMEOUT = 8,
  parameter int BLINK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  crossing_if.slave  bus
);

  localparam int TMAX = (WARN_CYCLES > MOVE_TIMEOUT) ? WARN_CYCLES : MOVE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  // The count runs load..0 inclusive, so load N-1 for an N-cycle window.
  localparam logic [TW-1:0] WARN_LOAD = TW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_west_q, last_west_d;
  logic       pend_e_q, pend_e_d, pend_w_q, pend_w_d;
  logic [1:0] cancela_q, cancela_d, semaforo_q, semaforo_d;
  logic       fault_q, fault_d;
  logic       expired, east_pick, any_req, lamp_on_d;

  assign east_pick = pick_east(bus.req_e, bus.req_w, last_west_q);
  assign any_req   = bus.req_e | bus.req_w;

  crossing_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state_d != state_q),
    .value  ((state_d == ST_WARN) ? WARN_LOAD : MOVE_LOAD),
    .en     (state_q inside {ST_WARN, ST_LOWER, ST_RAISE}),
    .expired(expired)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_west_d = last_west_q;
    pend_e_d    = pend_e_q;
    pend_w_d    = pend_w_q;

    // A request from the direction not holding the crossing is remembered.
    if (state_q inside {ST_WARN, ST_LOWER, ST_CLOSED}) begin
      if (grant_q[GRANT_E] && bus.req_w) pend_w_d = 1'b1;
      if (grant_q[GRANT_W] && bus.req_e) pend_e_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_RAISE: begin
        if (any_req) begin
          state_d     = (state_q == ST_IDLE) ? ST_WARN : ST_LOWER;
          grant_d     = grant_onehot(east_pick);
          last_west_d = !east_pick;
          // The loser of a tie waits as pending.
          pend_w_d    = east_pick && bus.req_w;
          pend_e_d    = !east_pick && bus.req_e;
        end else if (state_q == ST_RAISE) begin
          if (bus.gate_up) state_d = ST_IDLE;
          else if (expired) state_d = ST_FAULT;
        end
      end
      ST_WARN: if (expired) state_d = ST_LOWER;
      ST_LOWER: begin
        if (bus.gate_down) begin
          state_d = ST_CLOSED;
        end else if (expired) begin
          state_d = ST_FAULT;
          grant_d = '0;
        end
      end
      ST_CLOSED: begin
        // A same-cycle opposite request counts as pending, so check req too.
        if (grant_q[GRANT_E] && bus.clear_e) begin
          if (pend_w_q || bus.req_w) begin
            grant_d     = grant_onehot(1'b0);
            last_west_d = 1'b1;
            pend_w_d    = 1'b0;
          end else begin
            state_d = ST_RAISE;
            grant_d = '0;
          end
        end else if (grant_q[GRANT_W] && bus.clear_w) begin
          if (pend_e_q || bus.req_e) begin
            grant_d     = grant_onehot(1'b1);
            last_west_d = 1'b0;
            pend_e_d    = 1'b0;
          end else begin
            state_d = ST_RAISE;
            grant_d = '0;
          end
        end
      end
      ST_FAULT: grant_d = '0;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cancela_d  = (state_d == ST_LOWER) ? CAN_LOWER :
                 (state_d == ST_RAISE) ? CAN_RAISE : CAN_STOP;
    semaforo_d = (state_d == ST_IDLE || !lamp_on_d) ? SEM_OFF : SEM_RED;
    fault_d    = (state_d == ST_FAULT);
  end

`ifdef CROSSING_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  // Lamp starts lit on entry to WARN/FAULT and toggles every BLINK_CYCLES.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (state_d inside {ST_WARN, ST_FAULT} && state_d == state_q) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_on_d = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_on_d  = blink_on_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign lamp_on_d = blink_on_d;
`else
  // Steady light; any legal BLINK_CYCLES makes this constant 1.
  assign lamp_on_d = (BLINK_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_west_q <= 1'b1;  // east wins the first tie
      pend_e_q    <= 1'b0;
      pend_w_q    <= 1'b0;
      cancela_q   <= CAN_STOP;
      semaforo_q  <= SEM_OFF;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_west_q <= last_west_d;
      pend_e_q    <= pend_e_d;
      pend_w_q    <= pend_w_d;
      cancela_q   <= cancela_d;
      semaforo_q  <= semaforo_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.cancela  = cancela_q;
  assign bus.semaforo = semaforo_q;
  assign bus.grant    = grant_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_crossing_arbiter.sv
// tb_crossing_arbiter: directed vector table plus hand-written sequences for
// the motor timeout, fault stickiness and mid-movement reset.
module tb_crossing_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  crossing_if bus ();

  crossing_arbiter #(
    .WARN_CYCLES (4),
    .MOVE_TIMEOUT(8),
    .BLINK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       rst_n, re, rw, ce, cw, gd, gu;
    logic [6:0] exp;  // {cancela, semaforo, grant, fault}
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(input string name, input logic [6:0] ins,
                              input logic [1:0] can, input logic [1:0] sem,
                              input logic [1:0] gnt, input logic flt);
    vec_t v;
    v.name  = name;
    {v.rst_n, v.re, v.rw, v.ce, v.cw, v.gd, v.gu} = ins;
    v.exp   = {can, sem, gnt, flt};
    return v;
  endfunction

  task automatic drive(input logic [6:0] ins);
    {reset, bus.req_e, bus.req_w, bus.clear_e, bus.clear_w,
     bus.gate_down, bus.gate_up} = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {bus.cancela, bus.semaforo, bus.grant, bus.fault};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cancela=%b semaforo=%b grant=%b fault=%b, want cancela=%b semaforo=%b grant=%b fault=%b",
               name, act[6:5], act[4:3], act[2:1], act[0],
               exp[6:5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  // Input bit order: {rst_n, req_e, req_w, clear_e, clear_w, gate_down, gate_up}
  initial begin
    drive(7'b0000000);

    // Single eastbound train through a full cycle.
    vecs[0]  = mk("reset",       7'b0000000, 2'b00, 2'b00, 2'b00, 1'b0);
    vecs[1]  = mk("idle",        7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0);
    vecs[2]  = mk("warn1",       7'b1100000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[3]  = mk("warn2",       7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[4]  = mk("warn3",       7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[5]  = mk("warn4",       7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[6]  = mk("lower1",      7'b1000000, 2'b01, 2'b01, 2'b01, 1'b0);
    vecs[7]  = mk("lower2",      7'b1000000, 2'b01, 2'b01, 2'b01, 1'b0);
    vecs[8]  = mk("lower3",      7'b1000000, 2'b01, 2'b01, 2'b01, 1'b0);
    vecs[9]  = mk("closed",      7'b1000010, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[10] = mk("closed_hold", 7'b1000010, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[11] = mk("raise",       7'b1001000, 2'b10, 2'b01, 2'b00, 1'b0);
    vecs[12] = mk("raise_hold",  7'b1000000, 2'b10, 2'b01, 2'b00, 1'b0);
    vecs[13] = mk("idle_back",   7'b1000001, 2'b00, 2'b00, 2'b00, 1'b0);
    // Tie after reset: east first, west pending, handover without raising.
    vecs[14] = mk("reset2",      7'b0000000, 2'b00, 2'b00, 2'b00, 1'b0);
    vecs[15] = mk("tie_warn",    7'b1110000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[16] = mk("tie_warn2",   7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[17] = mk("tie_warn3",   7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[18] = mk("tie_warn4",   7'b1000000, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[19] = mk("tie_lower",   7'b1000000, 2'b01, 2'b01, 2'b01, 1'b0);
    vecs[20] = mk("tie_closed",  7'b1000010, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[21] = mk("handover",    7'b1001010, 2'b00, 2'b01, 2'b10, 1'b0);
    vecs[22] = mk("ign_clear",   7'b1001010, 2'b00, 2'b01, 2'b10, 1'b0);
    vecs[23] = mk("ign_req",     7'b1010010, 2'b00, 2'b01, 2'b10, 1'b0);
    vecs[24] = mk("raise_w",     7'b1000110, 2'b10, 2'b01, 2'b00, 1'b0);
    // Request during RAISE goes straight back to LOWER.
    vecs[25] = mk("raise_req",   7'b1010000, 2'b01, 2'b01, 2'b10, 1'b0);
    vecs[26] = mk("closed_w",    7'b1000010, 2'b00, 2'b01, 2'b10, 1'b0);
    vecs[27] = mk("req_clr_same",7'b1100110, 2'b00, 2'b01, 2'b01, 1'b0);
    vecs[28] = mk("raise_e",     7'b1001010, 2'b10, 2'b01, 2'b00, 1'b0);
    for (int i = 29; i <= 33; i++)
      vecs[i] = mk("raise_wait", 7'b1000000, 2'b10, 2'b01, 2'b00, 1'b0);
    // Tie in RAISE: last grant was east, so west wins.
    vecs[34] = mk("raise_tie",   7'b1110000, 2'b01, 2'b01, 2'b10, 1'b0);

    for (int i = 0; i < 35; i++) begin
      drive({vecs[i].rst_n, vecs[i].re, vecs[i].rw, vecs[i].ce,
             vecs[i].cw, vecs[i].gd, vecs[i].gu});
      tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // LOWER entered on the last vector with a fresh timer: 8 cycles, then FAULT.
    drive(7'b1000000);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("lower_hold%0d", i), {2'b01, 2'b01, 2'b10, 1'b0});
    end
    tick();
    check("fault_entry", {2'b00, 2'b01, 2'b00, 1'b1});

    // FAULT ignores every input until reset.
    drive(7'b1111111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_sticky", {2'b00, 2'b01, 2'b00, 1'b1});
    end

    // Reset mid-movement.
    drive(7'b0000000);
    tick();
    check("reset3", 7'b0);
    drive(7'b1100000);
    tick();
    check("rst_warn1", {2'b00, 2'b01, 2'b01, 1'b0});
    drive(7'b1000000);
    for (int i = 0; i < 3; i++) tick();
    tick();
    check("rst_lower", {2'b01, 2'b01, 2'b01, 1'b0});
    // A reset pulse between edges is never sampled.
    reset = 1'b0;
    #3;
    reset = 1'b1;
    check("no_edge_reset", {2'b01, 2'b01, 2'b01, 1'b0});
    tick();
    check("still_lower", {2'b01, 2'b01, 2'b01, 1'b0});
    drive(7'b0000000);
    tick();
    check("reset_lower", 7'b0);
    drive(7'b1000000);
    tick();
    check("idle_after_reset", 7'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
